// File: rtl/debug_module_jtag_vji_host_pkg.sv
// Shared definitions for the virtual-JTAG host that drives the Nios II debug slave.
// Holds the sequencer state enum, default scan widths and the command length field width.
package debug_module_jtag_pkg;

    // Default DR length; matches the debug slave's jdo/sr width.
    localparam int DR_W_DEF = 38;
    // Default virtual IR width.
    localparam int IR_W_DEF = 2;
    // Width of the cmd_len field.
    localparam int LEN_W    = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_UIR   = 3'd1,
        ST_CDR   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_UDR   = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

endpackage

// File: rtl/debug_module_jtag_vji_host_if.sv
// Command / response bundle of the virtual-JTAG host.
//   master : the on-chip initiator (offers commands, accepts responses)
//   slave  : the host block (accepts commands, offers responses)
// Signals:
//   cmd_valid/cmd_ready  command handshake
//   cmd_ir               IR value to drive on vji_ir_in
//   cmd_len              DR bits to shift (clamped to DR_W by the host)
//   cmd_data             DR bits, shifted out LSB first
//   rsp_valid/rsp_ready  response handshake
//   rsp_data             captured TDO bits, right-justified
//   rsp_ir_out           vji_ir_out captured during UIR
interface debug_module_jtag_vji_host_if
    import debug_module_jtag_pkg::*;
#(
    parameter int DR_W = DR_W_DEF,
    parameter int IR_W = IR_W_DEF
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [IR_W-1:0]  cmd_ir;
    logic [LEN_W-1:0] cmd_len;
    logic [DR_W-1:0]  cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DR_W-1:0]  rsp_data;
    logic [IR_W-1:0]  rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );

endinterface

// File: rtl/debug_module_jtag_vji_host_tck_gen.sv
// TCK phase generator for the virtual-JTAG host.
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   en            high while the host is in an active scan phase
//   tck           TCK: low for TCK_DIV cycles, then high for TCK_DIV cycles
//   period_start  high in the last cycle of a period, so anything registered on it
//                 takes its new value exactly at the start of the next period
//   rise_first    high in the first clk cycle of the TCK-high half
module debug_module_jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tck,
    output logic period_start,
    output logic rise_first
);

    localparam int P  = 2 * TCK_DIV;
    localparam int CW = $clog2(P);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Counter sits at 0 while disabled so the first active cycle opens a period.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(P - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tck          = en && (cnt_q >= CW'(TCK_DIV));
    assign period_start = en && (cnt_q == CW'(P - 1));
    assign rise_first   = en && (cnt_q == CW'(TCK_DIV));

endmodule

// File: rtl/debug_module_jtag_vji_host.sv
// Virtual-JTAG host: in-fabric initiator for the Nios II debug module's vji slave port.
// Accepts an IR/DR scan command, sequences UIR -> CDR -> SHIFT -> UDR on the vji_* lines
// with a divided TCK, captures TDO and ir_out, and returns the scanned-out bits.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   bus (slave)       command/response handshake bundle
//   vji_tck, vji_tdi  TCK and TDI to the slave; vji_tdo is TDO from the slave
//   vji_ir_in         IR value to the slave; vji_ir_out is the slave's IR readback
//   vji_uir/cdr/sdr/udr  one-hot virtual state strobes; vji_rti high when not scanning
module debug_module_jtag_vji_host
    import debug_module_jtag_pkg::*;
#(
    parameter int DR_W    = DR_W_DEF,
    parameter int IR_W    = IR_W_DEF,
    parameter int TCK_DIV = 2
) (
    input  logic                clk,
    input  logic                reset,
    debug_module_jtag_vji_host_if.slave bus,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_W-1:0]     vji_ir_in,
    input  logic [IR_W-1:0]     vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_q, bit_d;
    logic [DR_W-1:0]  tx_q, tx_d;
    logic [DR_W-1:0]  rx_q, rx_d;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic [IR_W-1:0]  irout_q, irout_d;

    logic             active;
    logic             period_start;
    logic             rise_first;
    logic [LEN_W-1:0] len_clamped;

    assign active = (state_q == ST_UIR) || (state_q == ST_CDR) ||
                    (state_q == ST_SHIFT) || (state_q == ST_UDR);

    assign len_clamped = (bus.cmd_len > LEN_W'(DR_W)) ? LEN_W'(DR_W) : bus.cmd_len;

    debug_module_jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk          (clk),
        .reset        (reset),
        .en           (active),
        .tck          (vji_tck),
        .period_start (period_start),
        .rise_first   (rise_first)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // Active phases advance only at period boundaries (period_start marks the last
    // cycle of a TCK period), so strobes always change at the TCK low start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.cmd_valid) state_d = ST_UIR;
            ST_UIR:   if (period_start) state_d = ST_CDR;
            ST_CDR:   if (period_start) state_d = (len_q == '0) ? ST_UDR : ST_SHIFT;
            ST_SHIFT: if (period_start && (bit_q == len_q - LEN_W'(1))) state_d = ST_UDR;
            ST_UDR:   if (period_start) state_d = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_RESP);
        vji_uir       = (state_q == ST_UIR);
        vji_cdr       = (state_q == ST_CDR);
        vji_sdr       = (state_q == ST_SHIFT);
        vji_udr       = (state_q == ST_UDR);
        vji_rti       = (state_q == ST_IDLE) || (state_q == ST_RESP);
        // tx_q[0] only moves at period boundaries, so TDI is stable over each period.
        vji_tdi       = (state_q == ST_SHIFT) && tx_q[0];
    end

    // ---------------- Datapath ----------------
    always_comb begin
        len_d   = len_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        ir_d    = ir_q;
        irout_d = irout_q;

        if ((state_q == ST_IDLE) && bus.cmd_valid) begin
            len_d = len_clamped;
            bit_d = '0;
            tx_d  = bus.cmd_data;
            // Clearing here keeps bits at and above len at zero in the response.
            rx_d  = '0;
            ir_d  = bus.cmd_ir;
        end

        if ((state_q == ST_UIR) && rise_first) begin
            irout_d = vji_ir_out;
        end

        if (state_q == ST_SHIFT) begin
            if (rise_first) begin
                rx_d[bit_q] = vji_tdo;
            end
            if (period_start) begin
                tx_d  = tx_q >> 1;
                bit_d = bit_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            ir_q    <= '0;
            irout_q <= '0;
        end else begin
            len_q   <= len_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            ir_q    <= ir_d;
            irout_q <= irout_d;
        end
    end

    assign vji_ir_in      = ir_q;
    assign bus.rsp_data   = rx_q;
    assign bus.rsp_ir_out = irout_q;

endmodule

// File: tb/tb_debug_module_jtag_vji_host.sv
// Self-checking bench for debug_module_jtag_vji_host. Expected responses are pushed to
// a scoreboard queue when a command is accepted and popped when rsp_valid appears.
// Cycle numbering: the cycle right after the accepting edge T is cycle T+1.
module tb_debug_module_jtag_vji_host;
    import debug_module_jtag_pkg::*;

    localparam int DR_W    = 38;
    localparam int IR_W    = 2;
    localparam int TCK_DIV = 2;
    localparam int P       = 2 * TCK_DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    debug_module_jtag_vji_host_if #(.DR_W(DR_W), .IR_W(IR_W)) bus ();

    logic            vji_tck, vji_tdi, vji_tdo;
    logic [IR_W-1:0] vji_ir_in, vji_ir_out;
    logic            vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
    logic [1:0]      tdo_mode;   // 0: loopback, 1: tied high, 2: tied low

    assign vji_tdo = (tdo_mode == 2'd0) ? vji_tdi : (tdo_mode == 2'd1);

    debug_module_jtag_vji_host #(
        .DR_W    (DR_W),
        .IR_W    (IR_W),
        .TCK_DIV (TCK_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .vji_tck    (vji_tck),
        .vji_tdi    (vji_tdi),
        .vji_tdo    (vji_tdo),
        .vji_ir_in  (vji_ir_in),
        .vji_ir_out (vji_ir_out),
        .vji_uir    (vji_uir),
        .vji_cdr    (vji_cdr),
        .vji_sdr    (vji_sdr),
        .vji_udr    (vji_udr),
        .vji_rti    (vji_rti)
    );

    typedef struct {
        logic [DR_W-1:0] data;
        logic [IR_W-1:0] ir_out;
        int              lat;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    // Monitor state, updated once per sample by step()
    int              rises, sdr_rises, uir_n, cdr_n, sdr_n, udr_n, ir_bad, idle_tck_bad;
    logic            tck_prev;
    logic [IR_W-1:0] ir_exp;
    logic            tdi_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr_mon();
        rises = 0; sdr_rises = 0; uir_n = 0; cdr_n = 0; sdr_n = 0; udr_n = 0;
        ir_bad = 0; idle_tck_bad = 0; tck_prev = 1'b0;
        tdi_q.delete();
    endtask

    task automatic step();
        logic act;
        @(posedge clk);
        #1;
        cyc++;
        act = vji_uir | vji_cdr | vji_sdr | vji_udr;
        if (vji_tck && !tck_prev) begin
            rises++;
            if (vji_sdr) begin
                sdr_rises++;
                tdi_q.push_back(vji_tdi);
            end
        end
        tck_prev = vji_tck;
        if (vji_uir) uir_n++;
        if (vji_cdr) cdr_n++;
        if (vji_sdr) sdr_n++;
        if (vji_udr) udr_n++;
        if (act && (vji_ir_in !== ir_exp)) ir_bad++;
        if (!act && vji_tck) idle_tck_bad++;
    endtask

    task automatic send(input logic [IR_W-1:0] ir, input int len, input logic [DR_W-1:0] data);
        int              len_eff;
        logic [DR_W-1:0] mask;
        exp_t            e;
        int              t;
        t = 0;
        while (!bus.cmd_ready && t < 200) begin
            step();
            t++;
        end
        if (!bus.cmd_ready) chk("cmd_ready_timeout", 64'(bus.cmd_ready), 64'd1);
        len_eff = (len > DR_W) ? DR_W : len;
        mask    = (len_eff >= DR_W) ? '1 : ((DR_W'(1) << len_eff) - DR_W'(1));
        case (tdo_mode)
            2'd0:    e.data = data & mask;
            2'd1:    e.data = mask;
            default: e.data = '0;
        endcase
        e.ir_out = vji_ir_out;
        e.lat    = 1 + (3 + len_eff) * P;
        sb.push_back(e);
        bus.cmd_valid = 1'b1;
        bus.cmd_ir    = ir;
        bus.cmd_len   = 6'(len);
        bus.cmd_data  = data;
        ir_exp        = ir;
        clr_mon();
        step();
        acc_cyc       = cyc;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = ~data;   // command inputs must be ignored after accept
        bus.cmd_ir    = ~ir;
        bus.cmd_len   = 6'd1;
        $display("cmd  ir=%0b len=%0d data=%0h at cycle %0d", ir, len, data, acc_cyc);
    endtask

    task automatic get_rsp(input int hold);
        int              t, bad, lat;
        exp_t            e;
        logic [DR_W-1:0] d0;
        logic [IR_W-1:0] i0;
        t = 0;
        while (!bus.rsp_valid && t < 400) begin
            step();
            t++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
        end else begin
            lat = cyc - acc_cyc + 1;
            if (sb.size() == 0) begin
                chk("sb_empty", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
                chk("rsp_ir_out", 64'(bus.rsp_ir_out), 64'(e.ir_out));
                chk("latency", 64'(lat), 64'(e.lat));
            end
            $display("rsp  data=%0h ir_out=%0b latency=%0d", bus.rsp_data, bus.rsp_ir_out, lat);
            d0 = bus.rsp_data;
            i0 = bus.rsp_ir_out;
            bad = 0;
            for (int k = 0; k < hold; k++) begin
                step();
                if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.rsp_ir_out !== i0 || bus.cmd_ready) bad++;
            end
            if (hold > 0) chk("bp_stable", 64'(bad), 64'd0);
            bus.rsp_ready = 1'b1;
            chk("no_turnaround", 64'(bus.cmd_ready), 64'd0);
            step();
            bus.rsp_ready = 1'b0;
            chk("rsp_dropped", 64'(bus.rsp_valid), 64'd0);
            chk("ready_after", 64'(bus.cmd_ready), 64'd1);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        chk({tag, "_rti"}, 64'(vji_rti), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(bus.rsp_data), 64'd0);
        chk({tag, "_rsp_ir_out"}, 64'(bus.rsp_ir_out), 64'd0);
        chk({tag, "_tck_tdi"}, 64'({vji_tck, vji_tdi}), 64'd0);
        chk({tag, "_ir_in"}, 64'(vji_ir_in), 64'd0);
        chk({tag, "_strobes"}, 64'({vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'd0);
    endtask

    initial begin
        logic [DR_W-1:0] rnd;
        int              t, seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_ir    = '0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        tdo_mode      = 2'd0;
        vji_ir_out    = 2'b10;
        ir_exp        = '0;
        clr_mon();

        // Reset
        reset = 1'b1;
        repeat (3) step();
        chk_reset_vals("reset");
        reset = 1'b0;
        clr_mon();
        repeat (6) step();
        chk("idle_tck_low", 64'(idle_tck_bad + rises), 64'd0);

        // Loopback, full length
        tdo_mode   = 2'd0;
        vji_ir_out = 2'b10;
        send(2'b01, 38, 38'h2A_5555_AAAA);
        get_rsp(0);
        chk("full_rises", 64'(rises), 64'd41);
        chk("full_uir_cyc", 64'(uir_n), 64'd4);
        chk("full_cdr_cyc", 64'(cdr_n), 64'd4);
        chk("full_udr_cyc", 64'(udr_n), 64'd4);
        chk("full_sdr_cyc", 64'(sdr_n), 64'(38 * P));
        chk("full_ir_in", 64'(ir_bad), 64'd0);
        chk("ir_in_retained", 64'(vji_ir_in), 64'b01);

        // Short scan, TDO tied high
        tdo_mode   = 2'd1;
        vji_ir_out = 2'b01;
        send(2'b11, 4, 38'b1011);
        get_rsp(0);
        chk("short_tdi_n", 64'(tdi_q.size()), 64'd4);
        if (tdi_q.size() == 4) begin
            chk("short_tdi0", 64'(tdi_q[0]), 64'd1);
            chk("short_tdi1", 64'(tdi_q[1]), 64'd1);
            chk("short_tdi2", 64'(tdi_q[2]), 64'd0);
            chk("short_tdi3", 64'(tdi_q[3]), 64'd1);
        end
        chk("short_rises", 64'(rises), 64'd7);

        // Zero length
        send(2'b10, 0, '1);
        get_rsp(0);
        chk("zero_sdr", 64'(sdr_n), 64'd0);
        chk("zero_rises", 64'(rises), 64'd3);

        // Backpressure, TDO tied low
        tdo_mode   = 2'd2;
        vji_ir_out = 2'b11;
        send(2'b01, 9, 38'h1FF);
        get_rsp(10);

        // Length above DR_W is clamped; random loopback data
        tdo_mode = 2'd0;
        rnd      = {6'($urandom), $urandom};
        send(2'b00, 50, rnd);
        get_rsp(0);
        chk("clamp_rises", 64'(rises), 64'd41);

        // Reset mid-SHIFT at bit 10
        vji_ir_out = 2'b10;
        send(2'b11, 38, 38'h3F_FFFF_FFFF);
        t = 0;
        while (sdr_rises < 10 && t < 300) begin
            step();
            t++;
        end
        chk("reach_bit10", 64'(sdr_rises), 64'd10);
        reset = 1'b1;
        step();
        chk_reset_vals("midrst");
        reset = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());   // the in-flight command is dropped
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (bus.rsp_valid) seen++;
        end
        chk("midrst_no_rsp", 64'(seen), 64'd0);
        vji_ir_out = 2'b01;
        send(2'b10, 12, 38'hABC);
        get_rsp(0);
        chk("after_rst_ir_in", 64'(ir_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/debug_module_jtag_vji_host.md
# debug_module_jtag_vji_host

In-fabric initiator for the Nios II debug module's virtual-JTAG slave port. It accepts an IR/DR scan command, then sequences the vji_* signals the debug slave consumes: TCK, TDI, UIR/CDR/SDR/UDR strobes, RTI and ir_in. It captures TDO and ir_out and returns the scanned-out data. It lets on-chip logic, such as a context-switch cache controller or a self-test sequencer, drive the OCI debug registers without an external JTAG cable, and it lets benches exercise the slave in simulation.

## Interface
Parameters:
- DR_W, 38: maximum DR scan length; matches the debug slave's jdo/sr width.
- IR_W, 2: virtual IR width.
- TCK_DIV, 2: clk cycles per TCK half-period (≥1); TCK period P = 2·TCK_DIV.

Ports:
- clk, in, 1: sole clock. One clock; reset is synchronous and active-high.
- reset, in, 1: synchronous, active-high.
- cmd_valid, in, 1: command offered.
- cmd_ready, out, 1: high only in IDLE.
- cmd_ir, in, IR_W: value driven on vji_ir_in.
- cmd_len, in, 6: DR bits to shift; values above DR_W are clamped to DR_W.
- cmd_data, in, DR_W: DR bits, shifted out LSB first.
- rsp_valid, out, 1: response held until accepted.
- rsp_ready, in, 1: response accept.
- rsp_data, out, DR_W: captured TDO bits, right-justified; bits ≥ len are 0.
- rsp_ir_out, out, IR_W: vji_ir_out sampled during the UIR phase.
- vji_tck, vji_tdi, out, 1 each: TCK and TDI to the slave.
- vji_tdo, in, 1: TDO from the slave.
- vji_ir_in, out, IR_W: IR value to the slave.
- vji_ir_out, in, IR_W: IR readback from the slave.
- vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, out, 1 each: virtual state strobes.

## Operation
- States: IDLE → UIR → CDR → SHIFT → UDR → RESP → IDLE.
- Phase lengths:
  - UIR, CDR and UDR last exactly one TCK period each.
  - SHIFT lasts len TCK periods; it is skipped entirely when len == 0 (CDR → UDR).
- Command accept: cmd_valid && cmd_ready latches cmd_ir, the clamped len and cmd_data. Command inputs are ignored afterwards.
- Strobes:
  - vji_uir, vji_cdr, vji_sdr and vji_udr are high exactly during their state; one-hot or all zero.
  - vji_rti is high in IDLE and RESP only.
- vji_ir_in:
  - Holds the latched cmd_ir from UIR through UDR.
  - Retains that value in RESP and IDLE; it is 0 after reset.
- SHIFT, per TCK period k (0..len-1):
  - vji_tdi = data[k] for the whole period.
  - vji_tdo is sampled into rsp_data[k] in the first clk cycle of the TCK-high half.
- rsp_ir_out: sampled in the first TCK-high cycle of UIR.
- RESP:
  - rsp_valid is held with rsp_data and rsp_ir_out stable until rsp_ready is seen.
  - Then the block goes to IDLE. cmd_ready rises the following cycle, so there is no same-cycle turnaround.
- Reset mid-operation:
  - The next cycle shows all outputs at their reset values.
  - The in-flight command is dropped and no rsp_valid is produced.
- Reset values:
  - cmd_ready = 1, vji_rti = 1.
  - All other outputs 0, including rsp_data, rsp_ir_out, vji_tck and vji_ir_in.

## Timing
- TCK waveform:
  - In IDLE and RESP, vji_tck is low.
  - In active phases, each period is low for TCK_DIV cycles, then high for TCK_DIV cycles.
- Phase boundaries:
  - Strobes, vji_ir_in and vji_tdi change only at period boundaries, i.e. the TCK falling edge / low start.
  - The slave therefore sees them stable across every TCK rise.
- Accept at edge T:
  - UIR spans T+1 … T+P.
  - CDR starts at T+1+P.
  - SHIFT starts at T+1+2P.
  - UDR starts at T+1+(2+len)·P.
  - rsp_valid rises at T+1+(3+len)·P.
- Defaults (P=4), latency from accept to rsp_valid:
  - len=38: 165 cycles.
  - len=0: 13 cycles.
- Number of TCK rising edges per command = 3 + len.

## Structure
- Package debug_module_jtag_pkg holds:
  - the state enum (IDLE, UIR, CDR, SHIFT, UDR, RESP);
  - the DR_W/IR_W defaults;
  - the len field width (6).
- Sub-module debug_module_jtag_tck_gen: phase counter generating vji_tck plus single-cycle strobes period_start and rise_first. It is enabled only in active states and cleared by reset.
- The top level holds the FSM, bit counter, TX shift register and RX capture register.

## Test plan
- Reset: assert reset for 3 cycles.
  - Outputs: cmd_ready=1, vji_rti=1, all others 0.
  - vji_tck stays low while idle.
- Loopback, full length: vji_tdo = vji_tdi, cmd_ir=2'b01, len=38, data=38'h2A_5555_AAAA.
  - rsp_data = 38'h2A_5555_AAAA and rsp_valid at T+165.
  - Exactly 41 TCK rises; uir, cdr and udr each high for 4 cycles; vji_ir_in = 2'b01 throughout.
- Short scan: len=4, data=4'b1011, vji_tdo tied 1.
  - vji_tdi per period = 1,1,0,1.
  - rsp_data = 38'h0F.
- Zero length: len=0.
  - vji_sdr never high.
  - rsp_valid at T+13; rsp_data = 0.
- Backpressure: hold rsp_ready low for 10 cycles.
  - rsp_valid, rsp_data and rsp_ir_out stay stable; cmd_ready stays 0.
  - After the handshake, the next command is accepted no earlier than 1 cycle later.
- Reset mid-SHIFT (bit 10 of 38): assert reset.
  - Next cycle: reset values.
  - rsp_valid never asserts; a new command afterwards completes normally.
